// File: rtl/encap_pkg.sv
// Shared types and width helpers for the encapsulating segmenter.
// A DFX payload word is cut into NUM_FLITS flits laid out as
// {payload, routing header, flit index}, index in the low bits.
package encap_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } seg_state_e;

  // Payload bits that fit beside the per-flit header.
  function automatic int payload_width(int aurora_w, int header_w);
    return aurora_w - header_w;
  endfunction

  // Flits needed to carry one DFX word (ceiling division).
  function automatic int num_flits(int dfx_w, int payload_w);
    return (dfx_w + payload_w - 1) / payload_w;
  endfunction

  // Width of the flit index field; never narrower than one bit.
  function automatic int idx_width(int nflits);
    return (nflits > 1) ? $clog2(nflits) : 1;
  endfunction

  // Width of the source-channel identifier; never narrower than one bit.
  function automatic int src_width(int nsrc);
    return (nsrc > 1) ? $clog2(nsrc) : 1;
  endfunction

  // Flit field offsets, low to high: index, routing header, payload.
  localparam int FLIT_IDX_LSB = 0;

  function automatic int flit_hdr_lsb(int idx_w);
    return idx_w;
  endfunction

  function automatic int flit_payload_lsb(int header_w);
    return header_w;
  endfunction

endpackage

// File: rtl/encap_segmenter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requests, searching from the
// channel after the most recently accepted one.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;

  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'((int'(ptr_q) + off) % N);
      if (!gnt_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_any   = 1'b1;
      end
    end
  end

  // Pointer moves past the winner only when its packet is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && gnt_any) begin
      ptr_d = IW'((int'(gnt_idx) + 1) % N);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/encap_segmenter.sv
// Encapsulating segmenter: accepts one wide DFX word from one of NUM_SRC
// channels and emits it as NUM_FLITS header-tagged flits, low payload first.
// Optional statistics counters are enabled by defining ENCAP_SEGMENTER_STATS_EN.
module encap_segmenter
  import encap_pkg::*;
#(
  parameter int DATA_DFX_WIDTH    = 1034,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int HEADER_WIDTH      = 9,
  parameter int NUM_SRC           = 2,
  localparam int PAYLOAD_WIDTH    = payload_width(AURORA_DATA_WIDTH, HEADER_WIDTH),
  localparam int NUM_FLITS        = num_flits(DATA_DFX_WIDTH, PAYLOAD_WIDTH),
  localparam int IDX_WIDTH        = idx_width(NUM_FLITS),
  localparam int HDR_IN_WIDTH     = HEADER_WIDTH - IDX_WIDTH,
  localparam int SRC_WIDTH        = src_width(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0]                s_valid,
  output logic [NUM_SRC-1:0]                s_ready,
  input  logic [NUM_SRC*DATA_DFX_WIDTH-1:0] s_data,
  input  logic [NUM_SRC*HDR_IN_WIDTH-1:0]   s_hdr,
  output logic [AURORA_DATA_WIDTH-1:0]      m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_last,
  output logic [SRC_WIDTH-1:0]              m_src
`ifdef ENCAP_SEGMENTER_STATS_EN
  ,
  output logic [31:0]                       pkt_count,
  output logic [31:0]                       stall_count
`endif
);

  // Shift register spans whole flits so the final flit's unused upper bits
  // are zero by construction.
  localparam int SHREG_WIDTH = NUM_FLITS * PAYLOAD_WIDTH;
  localparam int HDR_LSB     = flit_hdr_lsb(IDX_WIDTH);
  localparam int PAYLOAD_LSB = flit_payload_lsb(HEADER_WIDTH);

  seg_state_e              state_q, state_d;
  logic [SHREG_WIDTH-1:0]  shreg_q, shreg_d;
  logic [HDR_IN_WIDTH-1:0] hdr_q, hdr_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic                    last_q, last_d;
  logic [SRC_WIDTH-1:0]    src_q, src_d;

  logic [DATA_DFX_WIDTH-1:0] data_ch [NUM_SRC];
  logic [HDR_IN_WIDTH-1:0]   hdr_ch  [NUM_SRC];

  logic [NUM_SRC-1:0]   arb_req;
  logic [NUM_SRC-1:0]   arb_gnt;
  logic [SRC_WIDTH-1:0] arb_idx;
  logic                 arb_any;

  // Unpack the flat per-channel input buses.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ch
      assign data_ch[gi] = s_data[gi*DATA_DFX_WIDTH +: DATA_DFX_WIDTH];
      assign hdr_ch[gi]  = s_hdr[gi*HDR_IN_WIDTH +: HDR_IN_WIDTH];
    end
  endgenerate

  // Arbitrate only while idle and out of reset, so s_ready stays low otherwise.
  assign arb_req = (state_q == ST_IDLE && rst_n) ? s_valid : '0;

  rr_arbiter #(
    .N  (NUM_SRC),
    .IW (SRC_WIDTH)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .accept  (arb_any),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign s_ready = arb_gnt;

  // Next-state logic: capture the granted word in IDLE, shift out in SEND.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    hdr_d   = hdr_q;
    idx_d   = idx_q;
    last_d  = last_q;
    src_d   = src_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          shreg_d = SHREG_WIDTH'(data_ch[arb_idx]);
          hdr_d   = hdr_ch[arb_idx];
          idx_d   = '0;
          last_d  = (NUM_FLITS == 1);
          src_d   = arb_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_ready) begin
          if (last_q) begin
            // Final flit taken; the idle cycle that follows is the bubble.
            idx_d   = '0;
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            shreg_d = shreg_q >> PAYLOAD_WIDTH;
            idx_d   = idx_q + IDX_WIDTH'(1);
            last_d  = (idx_q + IDX_WIDTH'(1)) == IDX_WIDTH'(NUM_FLITS - 1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      hdr_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      hdr_q   <= hdr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      src_q   <= src_d;
    end
  end

  // Outputs are pure wiring of flops, so they hold under backpressure.
  assign m_valid = (state_q == ST_SEND);
  assign m_last  = last_q;
  assign m_src   = src_q;
  assign m_data[PAYLOAD_LSB +: PAYLOAD_WIDTH] = shreg_q[PAYLOAD_WIDTH-1:0];
  assign m_data[HDR_LSB +: HDR_IN_WIDTH]      = hdr_q;
  assign m_data[FLIT_IDX_LSB +: IDX_WIDTH]    = idx_q;

`ifdef ENCAP_SEGMENTER_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Count finished packets and backpressured cycles; both wrap.
  always_comb begin
    pkt_count_d   = pkt_count_q;
    stall_count_d = stall_count_q;
    if (m_valid && m_ready && m_last) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
    if (m_valid && !m_ready) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_encap_segmenter.sv
// Bench for encap_segmenter: directed scenarios with random payloads,
// checked cycle by cycle against a packet-level reference model.
// Define ENCAP_SEGMENTER_STATS_EN to also check the statistics counters.
module tb_encap_segmenter;

  localparam int DW  = 1034;
  localparam int AW  = 64;
  localparam int HW  = 9;
  localparam int NS  = 2;
  localparam int PW  = AW - HW;
  localparam int NF  = (DW + PW - 1) / PW;
  localparam int IW  = $clog2(NF);
  localparam int HIW = HW - IW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     s_valid;
  logic [NS-1:0]     s_ready;
  logic [NS*DW-1:0]  s_data;
  logic [NS*HIW-1:0] s_hdr;
  logic [AW-1:0]     m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [0:0]        m_src;
`ifdef ENCAP_SEGMENTER_STATS_EN
  logic [31:0]       pkt_count;
  logic [31:0]       stall_count;
`endif

  always #5 clk = ~clk;

  encap_segmenter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_hdr   (s_hdr),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .m_src   (m_src)
`ifdef ENCAP_SEGMENTER_STATS_EN
    ,
    .pkt_count   (pkt_count),
    .stall_count (stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the packet currently on the wire and arbitration history.
  logic [DW-1:0]  cur_data;
  logic [HIW-1:0] cur_hdr;
  int             cur_ch;
  int             cur_flit;
  bit             in_flight;
  int             rr_next;
  int             acc_ch;
  logic [31:0]    pkt_m;
  logic [31:0]    stall_m;
  int             grant_log[$];

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flit k carries payload bits [k*PW +: PW] of the word, then header, then index.
  function automatic logic [AW-1:0] exp_flit(input logic [DW-1:0] d, input logic [HIW-1:0] h, input int k);
    logic [DW-1:0] t;
    logic [PW-1:0] p;
    t = d >> (k * PW);
    p = t[PW-1:0];
    return {p, h, IW'(k)};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) begin
      r = {r[DW-33:0], $urandom()};
    end
    return r;
  endfunction

  task automatic model_reset();
    in_flight = 1'b0;
    cur_flit  = 0;
    cur_ch    = 0;
    rr_next   = 0;
    acc_ch    = -1;
    pkt_m     = '0;
    stall_m   = '0;
    grant_log.delete();
  endtask

  // One clock: check outputs against the model, then advance the model with the edge.
  task automatic step();
    logic [NS-1:0] exp_ready;
    int pick;
    int c;
    #1;
    exp_ready = '0;
    pick = -1;
    if (!in_flight) begin
      for (int o = 0; o < NS; o++) begin
        c = (rr_next + o) % NS;
        if (pick < 0 && s_valid[c]) pick = c;
      end
    end
    if (pick >= 0) exp_ready[pick] = 1'b1;
    chk("s_ready", AW'(s_ready), AW'(exp_ready));
    chk("m_valid", AW'(m_valid), AW'(in_flight));
    if (in_flight) begin
      chk("m_data", m_data, exp_flit(cur_data, cur_hdr, cur_flit));
      chk("m_last", AW'(m_last), AW'(cur_flit == NF - 1));
      chk("m_src", AW'(m_src), AW'(cur_ch));
    end
`ifdef ENCAP_SEGMENTER_STATS_EN
    chk("pkt_count", AW'(pkt_count), AW'(pkt_m));
    chk("stall_count", AW'(stall_count), AW'(stall_m));
`endif
    acc_ch = -1;
    @(posedge clk);
    if (in_flight) begin
      if (m_ready) begin
        if (cur_flit == NF - 1) begin
          in_flight = 1'b0;
          pkt_m = pkt_m + 32'd1;
        end else begin
          cur_flit++;
        end
      end else begin
        stall_m = stall_m + 32'd1;
      end
    end else if (pick >= 0) begin
      in_flight = 1'b1;
      cur_flit  = 0;
      cur_ch    = pick;
      cur_data  = s_data[pick*DW +: DW];
      cur_hdr   = s_hdr[pick*HIW +: HIW];
      rr_next   = (pick + 1) % NS;
      acc_ch    = pick;
      grant_log.push_back(pick);
    end
    #1;
  endtask

  task automatic wait_accept();
    acc_ch = -1;
    for (int n = 0; n < 64 && acc_ch < 0; n++) step();
    chk("accept_timeout", AW'(acc_ch >= 0), AW'(1));
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && in_flight; n++) step();
    chk("drain_timeout", AW'(in_flight), AW'(0));
    step();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
`ifdef ENCAP_SEGMENTER_STATS_EN
    logic [31:0] base;
`endif
    rst_n   = 1'b0;
    s_valid = 2'b11;
    s_data  = '0;
    s_hdr   = '0;
    m_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with requests pending on both channels.
    chk("rst_m_valid", AW'(m_valid), AW'(0));
    chk("rst_m_last", AW'(m_last), AW'(0));
    chk("rst_m_data", m_data, AW'(0));
    chk("rst_m_src", AW'(m_src), AW'(0));
    chk("rst_s_ready", AW'(s_ready), AW'(0));
    s_valid = '0;
    rst_n   = 1'b1;
    step();

    // Data 1 on channel 0, header A: payload bit 0 lands at flit bit 9 (0x200),
    // header A occupies bits 8:5 (0x140), index 0 -> 0x340.
    s_data[0 +: DW]  = DW'(1);
    s_hdr[0 +: HIW]  = 4'hA;
    s_valid          = 2'b01;
    m_ready          = 1'b1;
    wait_accept();
    s_valid = '0;
    chk("flit0_const", m_data, 64'h0000_0000_0000_0340);
    drain();
    $display("txn single ch0 data=1 hdr=A done");

    // Backpressure: hold m_ready low for 5 cycles while flit 3 is presented.
    s_data[DW +: DW]  = rand_data();
    s_hdr[HIW +: HIW] = HIW'($urandom);
    s_valid           = 2'b10;
    wait_accept();
    s_valid = '0;
    for (int n = 0; n < 8 && cur_flit < 3; n++) step();
    chk("stall_at_flit3", AW'(cur_flit), AW'(3));
`ifdef ENCAP_SEGMENTER_STATS_EN
    base = stall_m;
`endif
    m_ready = 1'b0;
    repeat (5) step();
    chk("stall_hold_data", m_data, exp_flit(cur_data, cur_hdr, 3));
`ifdef ENCAP_SEGMENTER_STATS_EN
    chk("stall_count_5", AW'(stall_count), AW'(base + 32'd5));
`endif
    m_ready = 1'b1;
    drain();
    $display("txn backpressure ch1 done");

    // All-ones word: the final flit keeps 44 payload ones, upper 11 bits zero.
    s_data[0 +: DW] = '1;
    s_hdr[0 +: HIW] = HIW'($urandom);
    s_valid         = 2'b01;
    wait_accept();
    s_valid = '0;
    for (int n = 0; n < 40 && cur_flit < NF - 1; n++) step();
    chk("ones_at_last", AW'(cur_flit), AW'(NF - 1));
    chk("ones_last_payload", AW'(m_data[AW-1:HW]), AW'(55'h0FFF_FFFF_FFFF));
    drain();
    $display("txn all-ones ch0 done");

    // All-zero word is a normal packet.
`ifdef ENCAP_SEGMENTER_STATS_EN
    base = pkt_m;
`endif
    s_data[DW +: DW]  = '0;
    s_hdr[HIW +: HIW] = '0;
    s_valid           = 2'b10;
    wait_accept();
    s_valid = '0;
    drain();
`ifdef ENCAP_SEGMENTER_STATS_EN
    chk("zero_pkt_count", AW'(pkt_count), AW'(base + 32'd1));
`endif
    $display("txn zero-data ch1 done");

    // Both channels always requesting after reset, random backpressure.
    do_reset();
    s_data[0 +: DW]   = rand_data();
    s_data[DW +: DW]  = rand_data();
    s_hdr             = NS*HIW'($urandom);
    s_valid           = 2'b11;
    for (int n = 0; n < 2000 && grant_log.size() < 6; n++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      step();
      if (acc_ch >= 0) begin
        s_data[acc_ch*DW +: DW]   = rand_data();
        s_hdr[acc_ch*HIW +: HIW]  = HIW'($urandom);
        $display("txn grant ch%0d", acc_ch);
      end
    end
    s_valid = '0;
    m_ready = 1'b1;
    chk("rr_grants_timeout", AW'(grant_log.size() >= 6), AW'(1));
    for (int i = 0; i < grant_log.size() && i < 6; i++) begin
      chk("rr_grant_order", AW'(grant_log[i]), AW'(i % 2));
    end
    drain();

    // Reset while flit 7 is on the wire, then a fresh packet.
    s_data[0 +: DW] = rand_data();
    s_hdr[0 +: HIW] = HIW'($urandom);
    s_valid         = 2'b01;
    wait_accept();
    s_valid = '0;
    for (int n = 0; n < 20 && cur_flit < 7; n++) step();
    chk("at_flit7", AW'(cur_flit), AW'(7));
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", AW'(m_valid), AW'(0));
    chk("midrst_m_data", m_data, AW'(0));
    chk("midrst_m_last", AW'(m_last), AW'(0));
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_edge_m_valid", AW'(m_valid), AW'(0));
    rst_n = 1'b1;
    s_data[DW +: DW]  = rand_data();
    s_hdr[HIW +: HIW] = HIW'($urandom);
    s_valid           = 2'b10;
    wait_accept();
    s_valid = '0;
    chk("after_rst_idx0", AW'(m_data[IW-1:0]), AW'(0));
    drain();
    $display("txn mid-packet reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
